// File: rtl/toom8_pointwise_mul.sv
// toom8_pointwise_mul: pointwise-product stage of the TOOM-8 multiplier.
// Captures 15 evaluated operand pairs on start, runs them through one shared
// pipelined signed multiplier and streams products 0..14 over valid/ready.
// Optional: define TOOM8_PW_ERR_EN to add the sticky protocol-error flag err.
module toom8_pointwise_mul #(
  parameter int MUL_STAGES = 3,
  parameter int OPW        = 155,
  parameter int NPTS       = 15
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NPTS*OPW-1:0]    a_bus,
  input  logic [NPTS*OPW-1:0]    b_bus,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_idx,
  output logic [2*OPW-1:0]       out_prod,
  output logic                   done
`ifdef TOOM8_PW_ERR_EN
  , output logic                 err
`endif
);

  localparam logic [3:0] LAST = 4'(NPTS-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [NPTS-1:0][OPW-1:0] a_q, b_q;
  logic [3:0]               cnt;
  logic                     en, issue;
  logic signed [OPW-1:0]    mul_a, mul_b;
  logic signed [2*OPW-1:0]  mul_p;

  // Stages 0..MUL_STAGES-1 form the multiplier; stage MUL_STAGES is the
  // output register, so out_* come straight from flops.
  logic [MUL_STAGES:0]                vld_pipe;
  logic [MUL_STAGES:0][3:0]           idx_pipe;
  logic [MUL_STAGES:0][2*OPW-1:0]     prod_pipe;

  assign en    = !out_valid || out_ready;
  assign issue = (state == RUN) && en;

  // Both operands are signed, so the 2*OPW context sign-extends before multiply.
  assign mul_a = a_q[cnt];
  assign mul_b = b_q[cnt];
  assign mul_p = mul_a * mul_b;

  assign out_valid = vld_pipe[MUL_STAGES];
  assign out_idx   = idx_pipe[MUL_STAGES];
  assign out_prod  = prod_pipe[MUL_STAGES];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Operand capture: only a start seen in IDLE may load the operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state == IDLE && start) begin
      a_q <= a_bus;
      b_q <= b_bus;
    end
  end

  // Issue counter: cleared on accept, advances once per issued pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (state == IDLE && start) cnt <= '0;
    else if (issue)                  cnt <= cnt + 4'd1;
  end

  // Multiplier/output pipeline: everything advances together only when en.
  // Bubbles carry zero index/product so idle outputs read back as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      idx_pipe  <= '0;
      prod_pipe <= '0;
    end else if (en) begin
      vld_pipe[0]  <= issue;
      idx_pipe[0]  <= issue ? cnt : 4'd0;
      prod_pipe[0] <= issue ? mul_p : '0;
      for (int s = 1; s <= MUL_STAGES; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        idx_pipe[s]  <= idx_pipe[s-1];
        prod_pipe[s] <= prod_pipe[s-1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN:   if (en && cnt == LAST) state_nx = DRAIN;
      DRAIN: if (out_valid && out_ready && out_idx == LAST) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef TOOM8_PW_ERR_EN
  logic [7:0] stall_cnt;

  // Sticky error: start while busy, or a stall reaching its 256th cycle.
  // stall_cnt saturates at 255, which marks 255 stalled edges already seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (out_valid && !out_ready)
        stall_cnt <= (stall_cnt == 8'hff) ? stall_cnt : stall_cnt + 8'd1;
      else
        stall_cnt <= '0;
      if ((start && state != IDLE) ||
          (out_valid && !out_ready && stall_cnt == 8'hff))
        err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_toom8_pointwise_mul.sv
// Bench for toom8_pointwise_mul: scoreboard of expected (index, product)
// pushed at start and popped on each output handshake, plus timing checks.
module tb_toom8_pointwise_mul;
  localparam int M    = 3;
  localparam int OPW  = 155;
  localparam int NPTS = 15;
  localparam int PW   = 2*OPW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NPTS*OPW-1:0]  a_bus, b_bus;
  logic                 busy, out_valid, out_ready, done;
  logic [3:0]           out_idx;
  logic [PW-1:0]        out_prod;
`ifdef TOOM8_PW_ERR_EN
  logic                 err;
`endif

  toom8_pointwise_mul #(.MUL_STAGES(M), .OPW(OPW), .NPTS(NPTS)) dut (
    .clk(clk), .rst(rst), .start(start), .a_bus(a_bus), .b_bus(b_bus),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_prod(out_prod), .done(done)
`ifdef TOOM8_PW_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef logic [PW+3:0] ent_t;
  ent_t sb_q[$];

  logic signed [OPW-1:0] a_v [NPTS];
  logic signed [OPW-1:0] b_v [NPTS];
  logic [PW-1:0]         got_prod [16];

  int checks = 0;
  int passed = 0;
  int first_v, done_c, busy_hi, stable_bad, aborted;

  function automatic logic [OPW-1:0] rnd_op();
    logic [159:0] t;
    for (int j = 0; j < 5; j++) t[j*32 +: 32] = $urandom;
    return t[OPW-1:0];
  endfunction

  // Drive one stream; optional stall on an index, abort after an index, or an
  // illegal start at a cycle. Scoreboard compares on every handshake.
  task automatic run_stream(input int stall_idx, input int stall_len,
                            input int abort_idx, input int illegal_c);
    int c, stall_left;
    bit stall_done;
    logic [3:0] hold_i;
    logic [PW-1:0] hold_p;
    logic signed [PW-1:0] p;
    ent_t e;
    first_v = -1; done_c = -1; busy_hi = 0; stable_bad = 0; aborted = 0;
    for (int k = 0; k < NPTS; k++) begin
      a_bus[k*OPW +: OPW] = a_v[k];
      b_bus[k*OPW +: OPW] = b_v[k];
      p = a_v[k] * b_v[k];
      sb_q.push_back({4'(k), p});
    end
    for (int k = 0; k < 16; k++) got_prod[k] = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0; stall_left = 0; stall_done = 0; hold_i = '0; hold_p = '0;
    while (c < 300 && done_c < 0 && aborted == 0) begin
      @(posedge clk); #1;
      c++;
      start = 1'b0;
      if (out_valid && first_v < 0) first_v = c;
      if (done && done_c < 0) done_c = c;
      if (busy) busy_hi++;
      if (abort_idx >= 0 && out_valid && out_idx == 4'(abort_idx + 1)) begin
        aborted = 1;
      end else begin
        if (stall_left > 0) begin
          if (!(out_valid && out_idx === hold_i && out_prod === hold_p)) stable_bad++;
          stall_left--;
          if (stall_left == 0) out_ready = 1'b1;
        end else if (!stall_done && stall_idx >= 0 && out_valid &&
                     out_idx == 4'(stall_idx)) begin
          out_ready = 1'b0; stall_left = stall_len; stall_done = 1;
          hold_i = out_idx; hold_p = out_prod;
        end
        if (out_valid && out_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            $display("FAIL scoreboard: unexpected output idx=%0d prod=%0h, none expected", out_idx, out_prod);
          end else begin
            e = sb_q.pop_front();
            if ({out_idx, out_prod} !== e)
              $display("FAIL scoreboard: got idx=%0d prod=%0h, want idx=%0d prod=%0h",
                       out_idx, out_prod, e[PW+3:PW], e[PW-1:0]);
            else passed++;
          end
          got_prod[out_idx] = out_prod;
        end
        if (c == illegal_c) begin
          start = 1'b1;
          for (int k = 0; k < NPTS; k++) a_bus[k*OPW +: OPW] = rnd_op();
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; a_bus = '0; b_bus = '0;
    #12;
    checks++;
    if ({busy, out_valid, done, out_idx, out_prod} !== '0)
      $display("FAIL reset_hold: outputs=%0h want 0", {busy, out_valid, done, out_idx, out_prod});
    else passed++;
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if ({busy, out_valid, done, out_idx, out_prod} !== '0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_idle: %0d nonzero cycles, want 0", bad);
    else passed++;
  endtask

  task automatic test_basic();
    for (int k = 0; k < NPTS; k++) begin a_v[k] = '0; b_v[k] = '0; end
    a_v[0] = 253; b_v[0] = 253; a_v[1] = 288; b_v[1] = 288; a_v[14] = 8; b_v[14] = 8;
    run_stream(-1, 0, -1, -1);
    checks++;
    if (first_v !== M + 1) $display("FAIL basic_first_valid: cycle %0d want %0d", first_v, M + 1);
    else passed++;
    checks++;
    if (done_c !== M + 16) $display("FAIL basic_done: cycle %0d want %0d", done_c, M + 16);
    else passed++;
    checks++;
    if (got_prod[0] !== PW'(64009) || got_prod[1] !== PW'(82944) ||
        got_prod[7] !== '0 || got_prod[14] !== PW'(64))
      $display("FAIL basic_values: p0=%0d p1=%0d p7=%0d p14=%0d want 64009 82944 0 64",
               got_prod[0], got_prod[1], got_prod[7], got_prod[14]);
    else passed++;
    checks++;
    if (busy_hi !== M + 16) $display("FAIL basic_busy: high %0d cycles want %0d", busy_hi, M + 16);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sb_q.size() != 0)
      $display("FAIL basic_end: busy=%0b done=%0b left=%0d want 0 0 0", busy, done, sb_q.size());
    else passed++;
  endtask

  task automatic test_signed();
    logic [PW-1:0] e13, e2;
    for (int k = 0; k < NPTS; k++) begin a_v[k] = rnd_op(); b_v[k] = rnd_op(); end
    a_v[13] = '0; a_v[13][OPW-1] = 1'b1; b_v[13] = a_v[13];
    a_v[2] = '1; b_v[2] = '1; b_v[2][OPW-1] = 1'b0;
    e13 = '0; e13[2*OPW-2] = 1'b1;
    e2 = '0; e2[OPW-2:0] = '1; e2 = -e2;
    run_stream(-1, 0, -1, -1);
    checks++;
    if (got_prod[13] !== e13) $display("FAIL signed_min_sq: got %0h want %0h", got_prod[13], e13);
    else passed++;
    checks++;
    if (got_prod[2] !== e2) $display("FAIL signed_neg: got %0h want %0h", got_prod[2], e2);
    else passed++;
    checks++;
    if (done_c !== M + 16) $display("FAIL signed_done: cycle %0d want %0d", done_c, M + 16);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < NPTS; k++) begin a_v[k] = rnd_op(); b_v[k] = rnd_op(); end
    run_stream(6, 5, -1, -1);
    checks++;
    if (stable_bad != 0) $display("FAIL bp_stable: %0d unstable cycles want 0", stable_bad);
    else passed++;
    checks++;
    if (done_c !== M + 21) $display("FAIL bp_done: cycle %0d want %0d", done_c, M + 21);
    else passed++;
    checks++;
    if (sb_q.size() != 0) $display("FAIL bp_drain: %0d left want 0", sb_q.size());
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    int dn;
    for (int k = 0; k < NPTS; k++) begin a_v[k] = rnd_op(); b_v[k] = rnd_op(); end
    run_stream(-1, 0, 8, -1);
    checks++;
    if (aborted != 1) $display("FAIL abort_reached: aborted=%0d want 1", aborted);
    else passed++;
    rst = 1'b1;
    sb_q.delete();
    #1;
    checks++;
    if ({busy, out_valid, done, out_idx, out_prod} !== '0)
      $display("FAIL abort_outputs: %0h want 0", {busy, out_valid, done, out_idx, out_prod});
    else passed++;
    @(posedge clk); #1 rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done || out_valid) dn++;
    end
    checks++;
    if (dn != 0) $display("FAIL abort_quiet: %0d active cycles want 0", dn);
    else passed++;
    for (int k = 0; k < NPTS; k++) begin a_v[k] = rnd_op(); b_v[k] = rnd_op(); end
    run_stream(-1, 0, -1, -1);
    checks++;
    if (done_c !== M + 16 || sb_q.size() != 0)
      $display("FAIL abort_restart: done cycle %0d left %0d want %0d 0", done_c, sb_q.size(), M + 16);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_start();
    for (int k = 0; k < NPTS; k++) begin a_v[k] = rnd_op(); b_v[k] = rnd_op(); end
    run_stream(-1, 0, -1, 5);
    checks++;
    if (done_c !== M + 16 || sb_q.size() != 0)
      $display("FAIL illegal_stream: done cycle %0d left %0d want %0d 0", done_c, sb_q.size(), M + 16);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL illegal_idle: busy=%0b want 0", busy);
    else passed++;
`ifdef TOOM8_PW_ERR_EN
    checks++;
    if (err !== 1'b1) $display("FAIL err_set: err=%0b want 1", err);
    else passed++;
    rst = 1'b1; #1;
    checks++;
    if (err !== 1'b0) $display("FAIL err_clear: err=%0b want 0", err);
    else passed++;
    @(posedge clk); #1 rst = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_reset_midstream();
    test_illegal_start();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
